// File: rtl/rv32_mod_load_store_unit.sv
// Load/store unit: runs one request/acknowledge data-bus access per start and
// returns sign/zero-extended load data.
// Optional feature macro: RV32_LSU_MISALIGN_TRAP_EN
//   defined   - misaligned accesses are aborted with err=1, misaligned=1
//   undefined - low address bits are forced aligned and the access proceeds
module rv32_mod_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  ram_req,
  input  logic        ram_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        misaligned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e          state_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q, done_q, err_q, bus_req_q, bus_we_q;
  logic [31:0]     rdata_q, bus_addr_q, bus_wdata_q;
  logic [3:0]      bus_be_q;

  logic [2:0]      f3;
  logic            illegal;
  logic [1:0]      eff_off;
  logic [3:0]      be_next;
  logic [31:0]     wdata_next;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [31:0]     load_ext;
  logic            timeout_hit;

  assign f3 = ram_req[2:0];

  // Decode of the request presented with start
  always_comb begin
    illegal = ram_req[3] | (f3 == 3'b011) | (f3[2:1] == 2'b11) | (ram_wr & f3[2]);
    // Halves ignore addr[0] and words ignore addr[1:0]: this is the forced alignment
    unique case (f3[1:0])
      2'b00:   eff_off = addr[1:0];
      2'b01:   eff_off = {addr[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
    unique case (f3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << eff_off;
        wdata_next = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << eff_off;
        wdata_next = {2{wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata;
      end
    endcase
  end

`ifdef RV32_LSU_MISALIGN_TRAP_EN
  logic mis;
  logic misaligned_q;
  assign mis = ((f3[1:0] == 2'b01) & addr[0]) | ((f3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  // Lane select and extension of the returned bus word
  always_comb begin
    lane_b = bus_rdata[{off_q, 3'b000} +: 8];
    lane_h = bus_rdata[{off_q[1], 4'b0000} +: 16];
    unique case (f3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'h0, lane_b};
      3'b101:  load_ext = {16'h0, lane_h};
      default: load_ext = bus_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Access sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
`ifdef RV32_LSU_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            err_q <= 1'b0;
`ifdef RV32_LSU_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
            if (illegal) begin
              state_q <= StResp;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
`ifdef RV32_LSU_MISALIGN_TRAP_EN
            end else if (mis) begin
              state_q      <= StResp;
              done_q       <= 1'b1;
              err_q        <= 1'b1;
              misaligned_q <= 1'b1;
`endif
            end else begin
              state_q     <= StReq;
              busy_q      <= 1'b1;
              bus_req_q   <= 1'b1;
              cnt_q       <= '0;
              f3_q        <= f3;
              off_q       <= eff_off;
              bus_we_q    <= ram_wr;
              bus_addr_q  <= {addr[31:2], 2'b00};
              bus_be_q    <= be_next;
              bus_wdata_q <= wdata_next;
            end
          end
        end
        StReq: begin
          if (bus_ack) begin
            state_q   <= StResp;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            bus_req_q <= 1'b0;
            err_q     <= bus_err;
            if (!bus_we_q && !bus_err) begin
              rdata_q <= load_ext;
            end
          end else if (timeout_hit) begin
            state_q   <= StResp;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            bus_req_q <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_rv32_mod_load_store_unit.sv
// Randomized bench for rv32_mod_load_store_unit against a behavioural model.
module tb_rv32_mod_load_store_unit;

  localparam int unsigned Tmo = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ram_req = 4'h0;
  logic        ram_wr = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err, misaligned, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_err = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_rdata = 32'h0;

  rv32_mod_load_store_unit #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ram_req    (ram_req),
    .ram_wr     (ram_wr),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .misaligned (misaligned),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access; dly = REQ cycle index on which ack is given (>= Tmo means never)
  task automatic run_access(input logic [3:0] req, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input logic be_err,
                            input int dly, input logic poke);
    int unsigned f3, size, off, v;
    bit illegal, mis, trap, tmo, e_err, e_mis;
    int e_lat, e_req, lat, reqcnt;
    logic [31:0] e_be, e_wd;
    bit got_done;

    f3      = int'(req[2:0]);
    size    = f3 % 4;
    illegal = req[3] || f3 == 3 || f3 == 6 || f3 == 7 || (wr && f3 >= 4);
    mis     = (size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0);
`ifdef RV32_LSU_MISALIGN_TRAP_EN
    trap  = illegal || mis;
    e_mis = mis && !illegal;
`else
    trap  = illegal;
    e_mis = 1'b0;
`endif
    off = a % 4;
    if (size == 1) off = off - off % 2;
    if (size == 2) off = 0;
    e_be = (size == 0) ? (32'd1 << off) : (size == 1) ? (32'd3 << off) : 32'd15;
    e_wd = (size == 0) ? (wd & 32'hFF) * 32'h01010101 :
           (size == 1) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    tmo   = !trap && dly >= int'(Tmo);
    e_err = trap || tmo || (!trap && be_err);
    e_req = trap ? 0 : (tmo ? int'(Tmo) : dly + 1);
    e_lat = e_req + 1;
    if (!e_err && !wr) begin
      v = rd >> (8 * off);
      if (size == 0) begin
        v = v & 32'hFF;
        if (f3 < 4 && v >= 128) v = v - 256;
      end else if (size == 1) begin
        v = v & 32'hFFFF;
        if (f3 < 4 && v >= 32768) v = v - 65536;
      end
      exp_rdata = v;
    end

    @(negedge clk);
    ram_req = req; ram_wr = wr; addr = a; wdata = wd; start = 1'b1;
    got_done = 0; reqcnt = 0; lat = 0;
    for (int c = 1; c <= 20 && !got_done; c++) begin
      @(negedge clk);
      start = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      if (done) begin
        got_done = 1; lat = c;
      end else if (bus_req) begin
        reqcnt++;
        check("busy_in_req", {31'h0, busy}, 32'h1);
        check("bus_we", {31'h0, bus_we}, {31'h0, wr});
        check("bus_addr", bus_addr, a & 32'hFFFFFFFC);
        check("bus_be", {28'h0, bus_be}, e_be);
        if (wr) check("bus_wdata", bus_wdata, e_wd);
        if (reqcnt - 1 == dly) begin
          bus_ack = 1'b1; bus_rdata = rd; bus_err = be_err;
        end
      end
    end
    check("done_latency", lat, e_lat);
    check("req_cycles", reqcnt, e_req);
    check("err", {31'h0, err}, {31'h0, e_err});
    check("misaligned", {31'h0, misaligned}, {31'h0, e_mis});
    check("rdata", rdata, exp_rdata);
    check("busy_at_done", {31'h0, busy}, 32'h0);
    check("req_at_done", {31'h0, bus_req}, 32'h0);
    if (poke) begin
      ram_req = 4'b0010; ram_wr = 1'b0; addr = 32'h40; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_in_resp_busy", {31'h0, busy}, 32'h0);
      check("start_in_resp_req", {31'h0, bus_req}, 32'h0);
    end
  endtask

  initial begin
    #12;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_req", {31'h0, bus_req}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_be", {28'h0, bus_be}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_access(4'b0010, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b1);
    run_access(4'b0000, 1'b0, 32'h103, 32'h0, 32'h80112233, 1'b0, 0, 1'b0);
    run_access(4'b0100, 1'b0, 32'h103, 32'h0, 32'h80112233, 1'b0, 1, 1'b0);
    run_access(4'b0001, 1'b0, 32'h102, 32'h0, 32'h80015A5A, 1'b0, 0, 1'b0);
    run_access(4'b0101, 1'b0, 32'h102, 32'h0, 32'h80015A5A, 1'b0, 2, 1'b0);
    run_access(4'b0000, 1'b1, 32'h201, 32'h000000AB, 32'h0, 1'b0, 0, 1'b0);
    run_access(4'b0001, 1'b1, 32'h202, 32'h00001234, 32'h0, 1'b0, 0, 1'b0);
    run_access(4'b0011, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 0, 1'b1);
    run_access(4'b1010, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    run_access(4'b0100, 1'b1, 32'h100, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    run_access(4'b0010, 1'b0, 32'h300, 32'h0, 32'h0, 1'b0, 10, 1'b0);
    run_access(4'b0010, 1'b0, 32'h300, 32'h0, 32'h12345678, 1'b1, 1, 1'b0);
    run_access(4'b0010, 1'b0, 32'h102, 32'h0, 32'hCAFEF00D, 1'b0, 0, 1'b0);
    run_access(4'b0001, 1'b0, 32'h101, 32'h0, 32'h7FFF8000, 1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of a request
    @(negedge clk);
    ram_req = 4'b0010; ram_wr = 1'b0; addr = 32'h500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_req", {31'h0, bus_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'h0, bus_req}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    exp_rdata = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_done_after_rst", {31'h0, done}, 32'h0);
    end
    bus_ack = 1'b0;

    // Randomized accesses
    for (int i = 0; i < 200; i++) begin
      logic [3:0] rq;
      int unsigned legal [5] = '{0, 1, 2, 4, 5};
      if ($urandom_range(0, 9) < 8) rq = 4'(legal[$urandom_range(0, 4)]);
      else rq = 4'($urandom);
      run_access(rq, 1'($urandom), $urandom, $urandom, $urandom,
                 ($urandom % 8) == 0, int'($urandom_range(0, 5)), ($urandom % 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
